// File: rtl/key_event_if.sv
// Key gesture event bundle: debounced key level in, registered level and
// one-cycle gesture event pulses out.
interface key_event_if;
   logic key_n;
   logic key_held;
   logic single_click;
   logic double_click;
   logic long_press;
   logic repeat_pulse;

   modport master (
      output key_n,
      input  key_held,
      input  single_click,
      input  double_click,
      input  long_press,
      input  repeat_pulse
   );

   modport slave (
      input  key_n,
      output key_held,
      output single_click,
      output double_click,
      output long_press,
      output repeat_pulse
   );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies a debounced active-low key into single/double click, long press
// and auto-repeat one-cycle pulses using one shared gesture timer.
module key_event_decoder #(
   parameter int LONG_CNT   = 50_000_000,
   parameter int REPEAT_CNT = 10_000_000,
   parameter int DCLICK_CNT = 15_000_000
) (
   input  logic        clk,
   input  logic        rst,
   key_event_if.slave  evt
);

   localparam int MAX_LR  = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
   localparam int MAX_CNT = (MAX_LR > DCLICK_CNT) ? MAX_LR : DCLICK_CNT;
   localparam int TW      = $clog2(MAX_CNT) + 1;

   localparam logic [TW-1:0] LONG_TC   = TW'(LONG_CNT - 1);
   localparam logic [TW-1:0] REPEAT_TC = TW'(REPEAT_CNT - 1);
   localparam logic [TW-1:0] DCLICK_TC = TW'(DCLICK_CNT - 1);
   localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
   localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PRESS1 = 3'd1;
   localparam logic [2:0] ST_WAIT2  = 3'd2;
   localparam logic [2:0] ST_PRESS2 = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;

   logic          key_d_q, key_d2_q, key_held_q;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, term_s, timer_inc_s;
   logic          single_q, single_d, double_q, double_d;
   logic          long_q, long_d, repeat_q, repeat_d;
   logic          press_s, release_s;

   assign press_s   = key_d2_q & ~key_d_q;
   assign release_s = ~key_d2_q & key_d_q;

   // Terminal count of the current state; the timer saturates there.
   always_comb begin
      case (state_q)
         ST_PRESS1, ST_PRESS2: term_s = LONG_TC;
         ST_WAIT2:             term_s = DCLICK_TC;
         ST_HOLD:              term_s = REPEAT_TC;
         default:              term_s = TIMER_ZERO;
      endcase
   end

   assign timer_inc_s = (timer_q == term_s) ? timer_q : timer_q + TIMER_ONE;

   // Gesture FSM; release beats terminal count, a press beats the click timeout.
   always_comb begin
      state_d  = state_q;
      single_d = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (press_s) state_d = ST_PRESS1;
            else         state_d = ST_IDLE;
         end
         ST_PRESS1: begin
            if (release_s) begin
               state_d = ST_WAIT2;
            end else if (timer_q == LONG_TC) begin
               state_d = ST_HOLD;
               long_d  = 1'b1;
            end else begin
               state_d = ST_PRESS1;
            end
         end
         ST_WAIT2: begin
            if (press_s) begin
               state_d = ST_PRESS2;
            end else if (timer_q == DCLICK_TC) begin
               state_d  = ST_IDLE;
               single_d = 1'b1;
            end else begin
               state_d = ST_WAIT2;
            end
         end
         ST_PRESS2: begin
            if (release_s) begin
               state_d  = ST_IDLE;
               double_d = 1'b1;
            end else if (timer_q == LONG_TC) begin
               state_d = ST_HOLD;
               long_d  = 1'b1;
            end else begin
               state_d = ST_PRESS2;
            end
         end
         ST_HOLD: begin
            if (release_s) begin
               state_d = ST_IDLE;
            end else if (timer_q == REPEAT_TC) begin
               state_d  = ST_HOLD;
               repeat_d = 1'b1;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      timer_d = ((state_d != state_q) || repeat_d) ? TIMER_ZERO : timer_inc_s;
   end

   // Input pipeline, state, timer and registered event outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_d_q    <= 1'b1;
         key_d2_q   <= 1'b1;
         key_held_q <= 1'b0;
         state_q    <= ST_IDLE;
         timer_q    <= TIMER_ZERO;
         single_q   <= 1'b0;
         double_q   <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         key_d_q    <= evt.key_n;
         key_d2_q   <= key_d_q;
         key_held_q <= ~key_d_q;
         state_q    <= state_d;
         timer_q    <= timer_d;
         single_q   <= single_d;
         double_q   <= double_d;
         long_q     <= long_d;
         repeat_q   <= repeat_d;
      end
   end

   assign evt.key_held     = key_held_q;
   assign evt.single_click = single_q;
   assign evt.double_click = double_q;
   assign evt.long_press   = long_q;
   assign evt.repeat_pulse = repeat_q;

endmodule
